// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for the redirect path: PC-select codes, redirect FSM states,
// and the flush-counter width.
package branch_redirect_ctrl_pkg;

    localparam int FCNT_W = 3;

    typedef enum logic [1:0] {
        PCPLUS4  = 2'b00,
        PCBRANCH = 2'b01,
        PCALUOUT = 2'b10,
        PCRSVD   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLAG_WAIT = 2'd1,
        FLUSH     = 2'd2
    } redir_state_e;

    function automatic logic is_taken(input logic [1:0] sel);
        return (sel == PCBRANCH) || (sel == PCALUOUT);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_flush_counter.sv
// Loadable down-counter timing the wrong-path squash; done_o is high when the count is zero.
// Load wins over decrement; decrement stops at zero.
module branch_flush_counter
    import branch_redirect_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [FCNT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              done_o
);

    logic [FCNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (dec_i && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: stalls decode on flag hazards, pulses pc_load one cycle
// after a taken resolve, then holds flush for FLUSH_CYCLES cycles.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic             br_cond,
    input  logic             flags_busy,
    input  logic [1:0]       branch,
    output logic             stall,
    output logic             pc_load,
    output logic [1:0]       pc_sel,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] taken_count,
    output logic             err
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    redir_state_e     state_q;
    logic             pc_load_q;
    logic [1:0]       pc_sel_q;
    logic             flush_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    logic in_idle, in_wait, in_flush;
    logic hazard, resolve, taken, fc_done;

    assign in_idle  = (state_q == IDLE);
    assign in_wait  = (state_q == FLAG_WAIT);
    assign in_flush = (state_q == FLUSH);

    // Only B.cond depends on flags; in FLAG_WAIT the branch resolves the cycle flags commit.
    assign hazard  = br_valid & br_cond & flags_busy;
    assign resolve = br_valid & ((in_idle & ~hazard) | (in_wait & ~flags_busy));
    assign taken   = resolve & is_taken(branch);
    assign stall   = (in_idle & hazard) | (in_wait & flags_busy);

    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    branch_flush_counter u_flush_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (taken),
        .load_val_i (FLUSH_LOAD),
        .dec_i      (in_flush & ~fc_done),
        .done_o     (fc_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_load_q <= 1'b0;
            pc_sel_q  <= PCPLUS4;
            flush_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pc_load_q <= 1'b0;
            case (state_q)
                IDLE, FLAG_WAIT: begin
                    if (taken) begin
                        state_q   <= FLUSH;
                        pc_load_q <= 1'b1;
                        pc_sel_q  <= branch;
                        flush_q   <= 1'b1;
                        cnt_q     <= cnt_d;
                    end else if (resolve) begin
                        state_q <= IDLE;
                        if (branch == PCRSVD)
                            err_q <= 1'b1;
                    end else if (in_idle && hazard) begin
                        state_q <= FLAG_WAIT;
                    end else if (in_wait && !flags_busy) begin
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (fc_done) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_load     = pc_load_q;
    assign pc_sel      = pc_sel_q;
    assign flush       = flush_q;
    assign busy        = ~in_idle;
    assign taken_count = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (default, and FLUSH_CYCLES=1/CNT_W=2)
// share stimulus and are checked every cycle against a cycle-count model plus literal checks.
module tb_branch_redirect_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       br_valid, br_cond, flags_busy;
    logic [1:0] branch;

    logic        s0, pl0, f0, b0, e0;
    logic [1:0]  ps0;
    logic [15:0] c0;
    logic        s1, pl1, f1, b1, e1;
    logic [1:0]  ps1;
    logic [1:0]  c1;

    int n_total = 0;
    int n_bad   = 0;
    int stall_seen = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_cond(br_cond),
        .flags_busy(flags_busy), .branch(branch), .stall(s0), .pc_load(pl0),
        .pc_sel(ps0), .flush(f0), .busy(b0), .taken_count(c0), .err(e0)
    );

    branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_cond(br_cond),
        .flags_busy(flags_busy), .branch(branch), .stall(s1), .pc_load(pl1),
        .pc_sel(ps1), .flush(f1), .busy(b1), .taken_count(c1), .err(e1)
    );

    // Model: mode 0 = free, 1 = waiting on flags, 2 = squashing (left = squash cycles remaining)
    int m_mode[2];
    int m_left[2];
    int m_pcl[2];
    int m_sel[2];
    int m_cnt[2];
    int m_err[2];

    function automatic int flush_len(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic int exp_stall(input int i);
        if (m_mode[i] == 0) return int'(br_valid & br_cond & flags_busy);
        if (m_mode[i] == 1) return int'(flags_busy);
        return 0;
    endfunction

    task automatic model_step(input int i);
        bit go;
        go = 1'b0;
        if (m_mode[i] == 2) begin
            m_pcl[i]  = 0;
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_mode[i] = 0;
        end else begin
            m_pcl[i] = 0;
            if (m_mode[i] == 0) begin
                if (br_valid && br_cond && flags_busy) m_mode[i] = 1;
                else if (br_valid) go = 1'b1;
            end else if (!flags_busy) begin
                m_mode[i] = 0;
                go = br_valid;
            end
            if (go) begin
                if (branch == 2'd1 || branch == 2'd2) begin
                    m_mode[i] = 2;
                    m_left[i] = flush_len(i);
                    m_pcl[i]  = 1;
                    m_sel[i]  = int'(branch);
                    if (m_cnt[i] < cnt_max(i)) m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    m_mode[i] = 0;
                    if (branch == 2'd3) m_err[i] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_left[i] = 0; m_pcl[i] = 0;
                m_sel[i]  = 0; m_cnt[i]  = 0; m_err[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (s0) stall_seen++;
        check("d0.stall",   s0,  exp_stall(0));
        check("d0.pc_load", pl0, m_pcl[0]);
        check("d0.flush",   f0,  int'(m_mode[0] == 2));
        check("d0.busy",    b0,  int'(m_mode[0] != 0));
        check("d0.count",   c0,  m_cnt[0]);
        check("d0.err",     e0,  m_err[0]);
        if (m_mode[0] == 2) check("d0.pc_sel", ps0, m_sel[0]);
        check("d1.stall",   s1,  exp_stall(1));
        check("d1.pc_load", pl1, m_pcl[1]);
        check("d1.flush",   f1,  int'(m_mode[1] == 2));
        check("d1.busy",    b1,  int'(m_mode[1] != 0));
        check("d1.count",   c1,  m_cnt[1]);
        check("d1.err",     e1,  m_err[1]);
        if (m_mode[1] == 2) check("d1.pc_sel", ps1, m_sel[1]);
    end

    task automatic drive(input logic bv, input logic bc, input logic fb, input logic [1:0] br);
        br_valid = bv; br_cond = bc; flags_busy = fb; branch = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        br_valid = 1'b0; br_cond = 1'b0; flags_busy = 1'b0; branch = 2'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst.pc_load", pl0, 0);
        check("rst.pc_sel",  ps0, 0);
        check("rst.flush",   f0,  0);
        check("rst.busy",    b0,  0);
        check("rst.count",   c0,  0);
        check("rst.err",     e0,  0);

        // Taken branch to PCBRANCH, two-cycle squash
        drive(1, 0, 0, 2'd1);
        check("t1.pc_load", pl0, 1);
        check("t1.pc_sel",  ps0, 1);
        check("t1.flush",   f0,  1);
        check("t1.count",   c0,  1);
        drive(0, 0, 0, 2'd0);
        check("t1.pc_load_gone", pl0, 0);
        check("t1.flush_2nd",    f0,  1);
        drive(0, 0, 0, 2'd0);
        check("t1.flush_end", f0, 0);
        check("t1.busy_end",  b0, 0);

        // B.cond waiting three cycles on in-flight flags
        stall_seen = 0;
        repeat (3) drive(1, 1, 1, 2'd2);
        drive(1, 1, 0, 2'd2);
        check("t2.stall_cycles", stall_seen, 3);
        check("t2.pc_load",      pl0, 1);
        check("t2.pc_sel",       ps0, 2);
        drive(0, 0, 0, 2'd0);
        drive(0, 0, 0, 2'd0);

        // Unconditional branch ignores flags_busy
        stall_seen = 0;
        drive(1, 0, 1, 2'd1);
        check("t3.stall_cycles", stall_seen, 0);
        check("t3.pc_load",      pl0, 1);
        check("t3.count",        c0,  3);
        drive(0, 0, 0, 2'd0);
        drive(0, 0, 0, 2'd0);

        // Not-taken, then reserved select
        drive(1, 0, 0, 2'd0);
        check("t4.nt_pc_load", pl0, 0);
        check("t4.nt_flush",   f0,  0);
        check("t4.nt_count",   c0,  3);
        drive(1, 0, 0, 2'd3);
        check("t4.err_set",  e0, 1);
        check("t4.rsv_load", pl0, 0);
        drive(0, 0, 0, 2'd0);
        check("t4.err_sticky", e0, 1);

        // Branch held through squash: only seen once back in IDLE
        repeat (6) drive(1, 0, 0, 2'd1);
        drive(0, 0, 0, 2'd0);
        drive(0, 0, 0, 2'd0);
        check("t5.count_d0",     c0, 5);
        check("t5.count_sat_d1", c1, 3);

        // Asynchronous reset in the second squash cycle
        drive(1, 0, 0, 2'd1);
        drive(0, 0, 0, 2'd0);
        check("t6.pre_flush", f0, 1);
        #2 reset = 1'b1;
        #1;
        check("t6.rst_flush",   f0,  0);
        check("t6.rst_pc_load", pl0, 0);
        check("t6.rst_busy",    b0,  0);
        check("t6.rst_count",   c0,  0);
        check("t6.rst_err",     e0,  0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1, 0, 0, 2'd2);
        check("t6.post_pc_load", pl0, 1);
        check("t6.post_pc_sel",  ps0, 2);
        check("t6.post_count",   c0,  1);
        repeat (3) drive(0, 0, 0, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
